onehot_wb_encoder: RTL and testbench



---
 rtl/onehot_wb_encoder.sv | 115 +++++++++++
 tb/tb_onehot_wb_encoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/onehot_wb_encoder.sv
// rtl/onehot_wb_encoder.sv - one-hot write strobe to register index encoder with 2-entry output FIFO
// Optional saturating multi-hot counter built only when ONEHOT_WB_ERRCNT_EN is defined.
module onehot_wb_encoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_onehot,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [7:0]        err_count
);

  logic [1:0]        count_q, count_d;
  logic [2:0]        sel0_q, sel1_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic              err0_q, err1_q;

  logic [2:0] enc_sel;
  logic       enc_multi;
  logic       accept, push, pop;

  // Reverse scan so the lowest set bit wins on multi-hot vectors.
  always_comb begin
    enc_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (in_onehot[i]) enc_sel = 3'(i);
    end
  end

  assign enc_multi = |(in_onehot & (in_onehot - 8'd1));

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_onehot != 8'h00);
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  // Slot 0 is always the head; it is left untouched when the FIFO drains so outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      sel0_q  <= 3'd0;
      data0_q <= '0;
      err0_q  <= 1'b0;
      sel1_q  <= 3'd0;
      data1_q <= '0;
      err1_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      case (count_q)
        2'd0: begin
          if (push) begin
            sel0_q  <= enc_sel;
            data0_q <= in_data;
            err0_q  <= enc_multi;
          end
        end
        2'd1: begin
          if (push && pop) begin
            sel0_q  <= enc_sel;
            data0_q <= in_data;
            err0_q  <= enc_multi;
          end else if (push) begin
            sel1_q  <= enc_sel;
            data1_q <= in_data;
            err1_q  <= enc_multi;
          end
        end
        default: begin
          if (pop) begin
            sel0_q  <= sel1_q;
            data0_q <= data1_q;
            err0_q  <= err1_q;
          end
        end
      endcase
    end
  end

  assign out_sel  = sel0_q;
  assign out_data = data0_q;
  assign out_err  = err0_q;

`ifdef ONEHOT_WB_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_multi && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_onehot_wb_encoder.sv
// tb/tb_onehot_wb_encoder.sv - directed self-checking bench for onehot_wb_encoder
module tb_onehot_wb_encoder;

`ifdef ONEHOT_WB_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_onehot;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_sel;
  logic [7:0] out_data;
  logic       out_err;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  onehot_wb_encoder #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_onehot(in_onehot), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_data(out_data),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
    if (!ERRCNT_EN) return 8'h00;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_onehot = 8'h00; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_sel !== 3'd0 || out_data !== 8'h00 || out_err !== 1'b0) begin
      failures++; $display("FAIL reset_head got sel=%0d data=%h err=%b exp 0/00/0", out_sel, out_data, out_err); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err_count got=%h exp=00", err_count); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_onehot = 8'b0000_1000; in_data = 8'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 8'hA5 || out_err !== 1'b0) begin
      failures++; $display("FAIL single_head got v=%b sel=%0d data=%h err=%b exp 1/3/a5/0", out_valid, out_sel, out_data, out_err); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    checks++; if (out_sel !== 3'd3 || out_data !== 8'hA5) begin
      failures++; $display("FAIL single_hold got sel=%0d data=%h exp 3/a5", out_sel, out_data); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_onehot = 8'h00; in_data = 8'h77; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL zero_vec cyc=%0d got v=%b rdy=%b exp 0/1", i, out_valid, in_ready); end
    end
    in_valid = 1'b0;
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL zero_err_count got=%h exp=00", err_count); end
  endtask

  task automatic test_multihot();
    in_valid = 1'b1; in_onehot = 8'b1010_0000; in_data = 8'h3C; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== 8'h3C || out_err !== 1'b1) begin
      failures++; $display("FAIL multi_head got v=%b sel=%0d data=%h err=%b exp 1/5/3c/1", out_valid, out_sel, out_data, out_err); end
    checks++; if (err_count !== exp_cnt(1)) begin failures++; $display("FAIL multi_err_count got=%h exp=%h", err_count, exp_cnt(1)); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL multi_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_onehot = 8'h02; in_data = 8'h11;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy1 got=%b exp=1", in_ready); end
    step();
    in_onehot = 8'h04; in_data = 8'h22;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy2 got=%b exp=1", in_ready); end
    step();
    in_onehot = 8'h08; in_data = 8'h33;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b0 || out_sel !== 3'd1 || out_data !== 8'h11) begin
      failures++; $display("FAIL b2b_held got rdy=%b sel=%0d data=%h exp 0/1/11", in_ready, out_sel, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 8'h22) begin
      failures++; $display("FAIL b2b_second got v=%b sel=%0d data=%h exp 1/2/22", out_valid, out_sel, out_data); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 8'h33) begin
      failures++; $display("FAIL b2b_third got v=%b sel=%0d data=%h exp 1/3/33", out_valid, out_sel, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_push_pop_and_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_onehot = 8'h01; in_data = 8'h55;
    step();
    in_onehot = 8'h80; in_data = 8'h77; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_sel !== 3'd7 || out_data !== 8'h77) begin
      failures++; $display("FAIL pushpop got v=%b rdy=%b sel=%0d data=%h exp 1/1/7/77", out_valid, in_ready, out_sel, out_data); end
    in_valid = 1'b1; in_onehot = 8'h00; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL zero_with_pop got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
    in_valid = 1'b1; in_onehot = 8'h06; in_data = 8'h99;
    step();
    in_onehot = 8'h40;
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL preflush_full got=%b exp=0", in_ready); end
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'h00 || out_sel !== 3'd0) begin
      failures++; $display("FAIL flush got v=%b rdy=%b cnt=%h sel=%0d exp 0/1/00/0", out_valid, in_ready, err_count, out_sel); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_onehot = 8'hFF; in_data = 8'hE1; out_ready = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 100) begin
        checks++; if (err_count !== exp_cnt(100)) begin
          failures++; $display("FAIL sat_mid got=%h exp=%h", err_count, exp_cnt(100)); end
      end
    end
    in_valid = 1'b0;
    checks++; if (err_count !== exp_cnt(260)) begin failures++; $display("FAIL sat_final got=%h exp=%h", err_count, exp_cnt(260)); end
    checks++; if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_err !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL sat_head got v=%b sel=%0d err=%b rdy=%b exp 1/0/1/1", out_valid, out_sel, out_err, in_ready); end
    step();
    checks++; if (err_count !== exp_cnt(260)) begin failures++; $display("FAIL sat_hold got=%h exp=%h", err_count, exp_cnt(260)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_multihot();
    test_back_to_back();
    test_push_pop_and_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
